// File: rtl/det_pkg.sv
// Shared types and sizes for the determinant-engine arbiter.
package det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RESP
  } state_t;

  localparam int RES_W     = 16;
  localparam int MAT_ELEMS = 16;

  function automatic int mat_w(input int elem_w);
    return MAT_ELEMS * elem_w;
  endfunction

endpackage

// File: rtl/det_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module det_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = (&req) ? ~last : req[1];
  end

endmodule

// File: rtl/det_arbiter.sv
// Two-requester front end for a shared 4x4 determinant engine.
// Optional WAIT timeout is enabled by defining DET_TIMEOUT_EN.
module det_arbiter
  import det_pkg::*;
#(
  parameter int  TIMEOUT_CYC = 64,
  parameter int  ELEM_W      = 8,
  localparam int MAT_W       = MAT_ELEMS * ELEM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_i,
  input  logic                    req1_i,
  input  logic [MAT_W-1:0]        mat0_i,
  input  logic [MAT_W-1:0]        mat1_i,
  output logic                    ack0_o,
  output logic                    ack1_o,
  output logic signed [RES_W-1:0] res_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    eng_start_o,
  output logic [MAT_W-1:0]        eng_mat_o,
  input  logic [RES_W-1:0]        eng_res_i,
  input  logic                    eng_done_i
);

  state_t state;
  logic   pend_id;
  logic   grant_id;
  logic   last_grant;
  logic   pick_grant;
  logic   pick_valid;
  logic   pend_req;

  det_rr_pick2 u_pick (
    .req   ({req1_i, req0_i}),
    .last  (last_grant),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign pend_req = pend_id ? req1_i : req0_i;

`ifdef DET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_reg;
  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_id     <= 1'b0;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      eng_start_o <= 1'b0;
      busy_o      <= 1'b0;
      res_o       <= '0;
      eng_mat_o   <= '0;
`ifdef DET_TIMEOUT_EN
      wait_cnt    <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      eng_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            pend_id <= pick_grant;
            busy_o  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // A requester that withdrew before its matrix was latched gets no job.
          if (pend_req) begin
            grant_id    <= pend_id;
            eng_mat_o   <= pend_id ? mat1_i : mat0_i;
            eng_start_o <= 1'b1;
            state       <= START;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        START: begin
`ifdef DET_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done_i) begin
            res_o  <= $signed(eng_res_i);
            ack0_o <= ~grant_id;
            ack1_o <= grant_id;
            state  <= RESP;
`ifdef DET_TIMEOUT_EN
            err_reg <= 1'b0;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            res_o   <= '0;
            err_reg <= 1'b1;
            ack0_o  <= ~grant_id;
            ack1_o  <= grant_id;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          last_grant <= grant_id;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_det_arbiter.sv
// Bench for det_arbiter: transaction-level timing model, bench-side engine, directed jobs.
module tb_det_arbiter;

`ifdef DET_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [127:0] mat0, mat1;
  logic         ack0_o, ack1_o, err_o, busy_o, eng_start_o;
  logic signed [15:0] res_o;
  logic [127:0] eng_mat_o;
  logic [15:0]  eng_res;
  logic         eng_done;

  int issue0 = 0, issue1 = 0, done0 = 0, done1 = 0;
  int cyc = 0;
  int total = 0, bad = 0;
  int ack_ids[$];
  int ack_cycs[$];

  // engine configuration, written by the stimulus process only
  int          eng_lat = 1;
  bit          eng_force = 0;
  logic [15:0] eng_force_val = '0;
  int          stray_cyc = -1;

  assign req0 = (issue0 > done0);
  assign req1 = (issue1 > done1);

  det_arbiter #(.TIMEOUT_CYC(TO), .ELEM_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_i      (req0),
    .req1_i      (req1),
    .mat0_i      (mat0),
    .mat1_i      (mat1),
    .ack0_o      (ack0_o),
    .ack1_o      (ack1_o),
    .res_o       (res_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .eng_start_o (eng_start_o),
    .eng_mat_o   (eng_mat_o),
    .eng_res_i   (eng_res),
    .eng_done_i  (eng_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int el(input logic [127:0] m, input int r, input int c);
    logic [7:0] b;
    b = m[(r*4+c)*8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic int det4(input logic [127:0] m);
    int d, s, cc;
    int mi[9];
    d = 0;
    for (int c = 0; c < 4; c++) begin
      cc = 0;
      for (int r = 1; r < 4; r++)
        for (int j = 0; j < 4; j++)
          if (j != c) begin
            mi[cc] = el(m, r, j);
            cc++;
          end
      s = (c % 2 == 0) ? 1 : -1;
      d += s * el(m, 0, c) * (mi[0]*(mi[4]*mi[8] - mi[5]*mi[7])
                            - mi[1]*(mi[3]*mi[8] - mi[5]*mi[6])
                            + mi[2]*(mi[3]*mi[7] - mi[4]*mi[6]));
    end
    return d;
  endfunction

  function automatic logic [127:0] set_el(input logic [127:0] m, input int r, input int c, input int v);
    logic [127:0] t;
    t = m;
    t[(r*4+c)*8 +: 8] = 8'(v);
    return t;
  endfunction

  function automatic logic [127:0] diag(input int a, input int b, input int c, input int d);
    return set_el(set_el(set_el(set_el(128'd0, 0, 0, a), 1, 1, b), 2, 2, c), 3, 3, d);
  endfunction

  // bench-side engine: done eng_lat cycles after the start pulse, result = det of latched operand
  int           eng_cnt = -1;
  logic [127:0] eng_cap = '0;
  always @(posedge clk) begin
    #1;
    eng_done = 1'b0;
    if (!rst_n) begin
      eng_cnt = -1;
    end else if (eng_start_o) begin
      eng_cap = eng_mat_o;
      eng_cnt = (eng_lat >= 1) ? eng_lat : -1;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_cnt  = -1;
      end
    end
    eng_res = eng_force ? eng_force_val : 16'(det4(eng_cap));
    if (cyc == stray_cyc) eng_done = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (ack0_o) begin
      done0++;
      ack_ids.push_back(0);
      ack_cycs.push_back(cyc);
      $display("ack req=0 res=%0h err=%0b cyc=%0d", res_o, err_o, cyc);
    end
    if (ack1_o) begin
      done1++;
      ack_ids.push_back(1);
      ack_cycs.push_back(cyc);
      $display("ack req=1 res=%0h err=%0b cyc=%0d", res_o, err_o, cyc);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // model: a job arbitrated in cycle t0 starts the engine at t0+2, acks at t0+3+L, frees at t0+4+L
  bit           m_free = 1, m_last = 1, m_gid = 0, m_err = 0, m_eerr = 0;
  int           m_t0 = 0, m_len = 0;
  logic [15:0]  m_res = '0, m_eres = '0;
  logic [127:0] m_mat = '0, m_eng_mat = '0;

  task automatic model_step();
    logic e_ack0, e_ack1, e_start, e_busy;
    logic [15:0] r;
    bit was_free;
    int k;
    e_ack0 = 0; e_ack1 = 0; e_start = 0; e_busy = 0;
    if (!rst_n) begin
      m_free = 1; m_last = 1; m_res = '0; m_err = 0; m_eng_mat = '0;
    end else begin
      was_free = m_free;
      if (!m_free) begin
        k = cyc - m_t0;
        e_busy = 1;
        if (k == 2) begin
          e_start   = 1;
          m_eng_mat = m_mat;
        end
        if (k == m_len + 3) begin
          if (m_gid) e_ack1 = 1; else e_ack0 = 1;
          m_res  = m_eres;
          m_err  = m_eerr;
          m_last = m_gid;
          m_free = 1;
        end
      end
      if (was_free && (req0 || req1)) begin
        m_gid  = (req0 && req1) ? !m_last : req1;
        m_t0   = cyc;
        m_free = 0;
        m_mat  = m_gid ? mat1 : mat0;
        m_len  = eng_lat;
        m_eres = eng_force ? eng_force_val : 16'(det4(m_mat));
        m_eerr = 0;
`ifdef DET_TIMEOUT_EN
        if (eng_lat < 1 || eng_lat > TO) begin
          m_len  = TO;
          m_eres = '0;
          m_eerr = 1;
        end
`endif
      end
    end
    r = res_o;
    chk("busy", busy_o, e_busy);
    chk("eng_start", eng_start_o, e_start);
    chk("ack0", ack0_o, e_ack0);
    chk("ack1", ack1_o, e_ack1);
    chk("res", r, m_res);
    chk("err", err_o, m_err);
    chk("eng_mat", eng_mat_o, m_eng_mat);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while ((done0 + done1) < target && n < budget) begin
      tick();
      n++;
    end
    chk("ack_arrived", ((done0 + done1) >= target), 1'b1);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    issue0 = done0;
    issue1 = done1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [127:0] mi, m2, m3;
  logic [15:0]  rr;
  int b, n_before;

  initial begin
    rst_n = 1'b0;
    mat0 = '0; mat1 = '0;
    mi = diag(1, 1, 1, 1);
    m2 = set_el(set_el(diag(2, 3, 4, 5), 0, 1, 7), 1, 3, -1);
    m3 = set_el(set_el(diag(1, 4, 1, 1), 0, 1, 2), 1, 0, 3);
    chk("pin_det_identity", det4(mi), 1);
    chk("pin_det_upper", det4(m2), 120);
    chk("pin_det_block", det4(m3), -2);

    repeat (3) tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_eng_mat", eng_mat_o, 128'd0);
    rr = res_o;
    chk("rst_res", rr, 16'h0000);
    rst_n = 1'b1;
    tick();

    // identity on requester 0
    mat0 = mi; eng_lat = 9; b = ack_ids.size();
    issue0++;
    wait_acks(done0 + done1 + 1, 100);
    rr = res_o;
    chk("ident_res", rr, 16'h0001);
    chk("ident_err", err_o, 1'b0);
    chk("ident_id", ack_ids[b], 0);

    // simultaneous requests from reset: 0 first, then 1 with 4+L spacing
    do_reset();
    mat0 = m2; mat1 = m3; eng_lat = 3; b = ack_ids.size();
    issue0++; issue1++;
    wait_acks(done0 + done1 + 2, 100);
    chk("tie_first", ack_ids[b], 0);
    chk("tie_second", ack_ids[b+1], 1);
    chk("tie_gap", ack_cycs[b+1] - ack_cycs[b], 7);
    rr = res_o;
    chk("tie_res", rr, 16'hFFFE);

    // both held for four jobs
    eng_lat = 5; b = ack_ids.size();
    issue0 += 2; issue1 += 2;
    wait_acks(done0 + done1 + 4, 200);
    for (int i = 0; i < 4; i++) chk("alt_id", ack_ids[b+i], i % 2);

`ifndef DET_TIMEOUT_EN
    // long engine latency never aborts without the timeout feature
    mat1 = m2; eng_lat = 40;
    issue1++;
    wait_acks(done0 + done1 + 1, 100);
    rr = res_o;
    chk("long_res", rr, 16'h0078);
`endif

    // reset in the middle of WAIT, then a stray done
    mat0 = m3; eng_lat = 30; n_before = done0 + done1;
    issue0++;
    repeat (10) tick();
    do_reset();
    stray_cyc = cyc + 2;
    repeat (6) tick();
    chk("rstw_busy", busy_o, 1'b0);
    chk("rstw_acks", done0 + done1, n_before);
    rr = res_o;
    chk("rstw_res", rr, 16'h0000);
    mat0 = mi; eng_lat = 4;
    issue0++;
    wait_acks(done0 + done1 + 1, 100);
    rr = res_o;
    chk("rstw_next_res", rr, 16'h0001);

`ifdef DET_TIMEOUT_EN
    eng_lat = -1;
    issue0++;
    wait_acks(done0 + done1 + 1, 100);
    rr = res_o;
    chk("to_res", rr, 16'h0000);
    chk("to_err", err_o, 1'b1);
    mat0 = m3; eng_lat = 2;
    issue0++;
    wait_acks(done0 + done1 + 1, 100);
    rr = res_o;
    chk("to_after_res", rr, 16'hFFFE);
    chk("to_after_err", err_o, 1'b0);
    eng_lat = TO; eng_force = 1; eng_force_val = 16'hFFF9;
    issue1++;
    wait_acks(done0 + done1 + 1, 100);
    rr = res_o;
    chk("expiry_res", rr, 16'hFFF9);
    chk("expiry_err", err_o, 1'b0);
    eng_force = 0;
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/det_arbiter.md
DET_ARBITER -- requirements
Module: det_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: the number of WAIT cycles after which a job is aborted (used only when DET_TIMEOUT_EN is defined).
REQ-002 SHALL have parameter ELEM_W, default 8: the matrix element width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req0_i / req1_i, input, 1 bit each: requester job request, held high until that requester's ack.
REQ-006 SHALL have port mat0_i / mat1_i, input, 16*ELEM_W bits each: the requester's 4x4 matrix, row-major, element a in the LSBs; stable while req is high.
REQ-007 SHALL have port ack0_o / ack1_o, output, 1 bit each: one-cycle completion pulse to the requester.
REQ-008 SHALL have port res_o, output, 16 bits signed: the determinant, valid only in an ack cycle.
REQ-009 SHALL have port err_o, output, 1 bit: timeout flag, valid only in an ack cycle.
REQ-010 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port eng_start_o, output, 1 bit: one-cycle start pulse to the shared 4x4 determinant engine.
REQ-012 SHALL have port eng_mat_o, output, 16*ELEM_W bits: the engine matrix operand.
REQ-013 SHALL have port eng_res_i, input, 16 bits: the engine result.
REQ-014 SHALL have port eng_done_i, input, 1 bit: one-cycle engine completion pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD, START, WAIT and RESP.
REQ-016 IDLE SHALL go to LOAD when any req is high; the grant SHALL be resolved in this cycle.
REQ-017 Arbitration SHALL be round-robin: if both reqs are high, grant the requester not granted last; if one req is high, grant it.
REQ-018 LOAD SHALL latch the granted matrix into eng_mat_o and the grant id into a register, then go to START.
REQ-019 START SHALL assert eng_start_o for exactly one cycle, then go to WAIT.
REQ-020 eng_mat_o SHALL stay unchanged from LOAD until the job leaves WAIT, because the engine reads its operands over multiple cycles.
REQ-021 WAIT SHALL, on eng_done_i, capture eng_res_i into res_o, clear err_o, and go to RESP.
REQ-022 RESP SHALL pulse ack of the granted requester only, update last_grant, and return to IDLE.
REQ-023 Back-to-back jobs SHALL cost 4 cycles of overhead: IDLE, LOAD, START and RESP.
REQ-024 eng_done_i outside WAIT SHALL be ignored.
REQ-025 A req that drops before LOAD SHALL be ignored; a req that drops after LOAD SHALL not abort the job.
REQ-026 A req still high on the cycle after its own ack SHALL start a new job.
REQ-027 res_o and err_o SHALL hold their values between acks.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ack*_o=0, eng_start_o=0, busy_o=0, res_o=0, err_o=0, eng_mat_o=0, and last_grant=1, so that req0 wins the first tie.
REQ-029 Reset during WAIT SHALL abandon the job without an ack; a late eng_done_i SHALL be ignored per REQ-024.

Configuration
REQ-030 With DET_TIMEOUT_EN defined, WAIT SHALL count cycles; at TIMEOUT_CYC cycles without done it SHALL go to RESP with res_o=0 and err_o=1.
REQ-031 With DET_TIMEOUT_EN defined, the counter SHALL clear on entry to WAIT, and an eng_done_i arriving in the expiry cycle SHALL take priority over the timeout.
REQ-032 Without DET_TIMEOUT_EN, there SHALL be no counter, WAIT SHALL wait indefinitely, and err_o SHALL be tied to 0.

Structure
REQ-033 Package det_pkg SHALL hold the state enum, the result width 16 and the matrix width 16*ELEM_W.
REQ-034 The round-robin pick SHALL be the sub-module det_rr_pick2: inputs req[1:0] and last; output grant id and valid.

Verification
REQ-035 Identity matrix on req0, engine model returning 1 after 9 cycles -> eng_start_o pulses once, ack0_o=1, res_o=1, err_o=0, ack1_o=0.
REQ-036 req0 and req1 both raised in the same cycle, first from reset -> req0 is served first, then req1 with no idle gap beyond REQ-023; acks arrive in order 0 then 1.
REQ-037 Both reqs held continuously for 4 jobs -> grants alternate 0,1,0,1.
REQ-038 DET_TIMEOUT_EN defined, TIMEOUT_CYC=16, engine never asserts done -> ack after 16 WAIT cycles with res_o=0, err_o=1; a later job succeeds normally.
REQ-039 DET_TIMEOUT_EN defined, done in exactly the expiry cycle with eng_res_i=-7 -> res_o=16'hFFF9, err_o=0.
REQ-040 rst_n pulsed low mid-WAIT, then a stray eng_done_i -> no ack, all outputs 0, FSM stays in IDLE; the next req0 completes normally.
